// File: rtl/mem_port_arbiter_pkg.sv
// riscv_mem_pkg: shared types and size encodings for the memory port arbiter
package riscv_mem_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the shared port
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic              m_we;
    logic [1:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;
    logic              bus_err;
    logic              busy;
    modport master (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ready, m_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, m_req, m_we, m_size, m_addr, m_wdata, bus_err, busy
    );
    modport slave (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ready, m_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, m_req, m_we, m_size, m_addr, m_wdata, bus_err, busy
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: grant decision, D wins unless its burst quota is spent while IF waits
module mem_arb_pick #(
    parameter int BW             = 3,
    parameter int DATA_BURST_MAX = 4
) (
    input  logic          d_req,
    input  logic          if_req,
    input  logic [BW-1:0] bcnt,
    output logic          gnt_d
);
    assign gnt_d = (d_req && bcnt < BW'(DATA_BURST_MAX)) || !if_req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store with timeout abort
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.master  bus
);
    localparam int BW = $clog2(DATA_BURST_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nxt;
    owner_t        owner;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic          err;
    logic          gnt_d;
    logic          req_any;
    logic          timeout;

    assign req_any = bus.if_req || bus.d_req;
    assign timeout = !bus.m_ready && tcnt == TW'(TIMEOUT_CYCLES - 1);

    mem_arb_pick #(.BW(BW), .DATA_BURST_MAX(DATA_BURST_MAX)) u_pick (
        .d_req  (bus.d_req),
        .if_req (bus.if_req),
        .bcnt   (bcnt),
        .gnt_d  (gnt_d)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt   = state;
        bus.m_req   = 1'b0;
        bus.if_ack  = 1'b0;
        bus.d_ack   = 1'b0;
        bus.bus_err = 1'b0;
        bus.busy    = 1'b0;
        case (state)
            IDLE:  state_nxt = req_any ? ISSUE : IDLE;
            ISSUE: begin
                state_nxt = (bus.m_ready || timeout) ? RESP : ISSUE;
                bus.m_req = 1'b1;
                bus.busy  = 1'b1;
            end
            RESP: begin
                state_nxt   = IDLE;
                bus.if_ack  = owner == OWN_IF;
                bus.d_ack   = owner == OWN_D;
                bus.bus_err = err;
                bus.busy    = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst count only grows while IF is actually waiting; it saturates at the quota.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            owner        <= OWN_IF;
            bcnt         <= '0;
            tcnt         <= '0;
            err          <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_size   <= '0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else if (state == IDLE && req_any) begin
            owner       <= gnt_d ? OWN_D : OWN_IF;
            bus.m_we    <= gnt_d && bus.d_we;
            bus.m_size  <= gnt_d ? bus.d_size : SZ_WORD;
            bus.m_addr  <= gnt_d ? bus.d_addr : bus.if_addr;
            bus.m_wdata <= gnt_d ? bus.d_wdata : '0;
            bcnt        <= !(gnt_d && bus.if_req) ? '0 : bcnt == BW'(DATA_BURST_MAX) ? bcnt : bcnt + BW'(1);
            tcnt        <= '0;
            err         <= 1'b0;
        end else if (state == ISSUE) begin
            if (bus.m_ready) begin
                if (owner == OWN_D) bus.d_rdata  <= bus.m_rdata;
                else                bus.if_rdata <= bus.m_rdata;
            end else begin
                tcnt <= tcnt + TW'(1);
                if (timeout) begin
                    err <= 1'b1;
                    if (owner == OWN_D) bus.d_rdata  <= '0;
                    else                bus.if_rdata <= '0;
                end
            end
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, timeout and reset abort
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_dead = 1'b0;
    int n_checks = 0;
    int n_err = 0;
    int n_if_ack = 0;
    int n_d_ack = 0;
    int n_mreq = 0;
    logic mreq_q = 1'b0;
    bit order[$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_BURST_MAX(4), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.m_ready = bus.m_req && !mem_dead;
    assign bus.m_rdata = (bus.m_addr == 32'h40) ? 32'h0050_0093 : bus.m_addr ^ 32'hA5A5_0000;

    always @(negedge clk) begin
        if (bus.if_ack) begin
            n_if_ack <= n_if_ack + 1;
            order.push_back(1'b0);
        end
        if (bus.d_ack) begin
            n_d_ack <= n_d_ack + 1;
            order.push_back(1'b1);
        end
        if (bus.m_req && !mreq_q) n_mreq <= n_mreq + 1;
        mreq_q <= bus.m_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_if, base_mreq, base_ord, hi, acks;
        bit got_ack;
        logic [3:0] exp_ord;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_mreq", bus.m_req, 0);
        check("rst_acks", {bus.if_ack, bus.d_ack, bus.bus_err}, 0);
        check("rst_maddr", bus.m_addr, 0);
        check("rst_ifrdata", bus.if_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single fetch, k=0
        base_if = n_if_ack; base_mreq = n_mreq;
        cyc();
        bus.if_req = 1; bus.if_addr = 32'h40;
        @(negedge clk); check("f_idle_busy", bus.busy, 0);
        cyc(); @(negedge clk);
        check("f_mreq", bus.m_req, 1);
        check("f_maddr", bus.m_addr, 32'h40);
        check("f_mwe", bus.m_we, 0);
        check("f_msize", bus.m_size, 2);
        cyc(); @(negedge clk);
        check("f_ack", bus.if_ack, 1);
        check("f_rdata", bus.if_rdata, 32'h0050_0093);
        check("f_dack", bus.d_ack, 0);
        cyc();
        bus.if_req = 0;
        @(negedge clk);
        check("f_busy_low", bus.busy, 0);
        repeat (3) cyc();
        check("f_one_ack", n_if_ack - base_if, 1);
        check("f_one_mreq", n_mreq - base_mreq, 1);

        // simultaneous store and fetch
        cyc();
        bus.if_req = 1; bus.if_addr = 32'h44;
        bus.d_req = 1; bus.d_we = 1; bus.d_size = 2; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        cyc(); @(negedge clk);
        check("s_mwe", bus.m_we, 1);
        check("s_maddr", bus.m_addr, 32'h100);
        check("s_mwdata", bus.m_wdata, 32'hDEAD_BEEF);
        check("s_msize", bus.m_size, 2);
        cyc(); @(negedge clk);
        check("s_dack", {bus.d_ack, bus.if_ack}, 2'b10);
        cyc();
        bus.d_req = 0;
        cyc(); @(negedge clk);
        check("s_if_maddr", bus.m_addr, 32'h44);
        check("s_if_mwe", bus.m_we, 0);
        cyc(); @(negedge clk);
        check("s_if_ack", bus.if_ack, 1);
        check("s_if_rdata", bus.if_rdata, 32'hA5A5_0044);
        cyc();
        bus.if_req = 0;
        repeat (2) cyc();

        // burst limit with both requesters held
        base_ord = order.size();
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 1; bus.d_addr = 32'h300;
        bus.if_req = 1; bus.if_addr = 32'h80;
        acks = 0;
        for (int i = 0; i < 40 && acks < 6; i++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) acks++;
        end
        cyc();
        bus.d_req = 0; bus.if_req = 0;
        repeat (2) cyc();
        check("b_acks", order.size() - base_ord, 6);
        exp_ord = 4'b1111;
        for (int i = 0; i < 4; i++) check($sformatf("b_ord%0d", i), order[base_ord + i], exp_ord[i]);
        check("b_ord4_if", order[base_ord + 4], 0);
        check("b_ord5_d", order[base_ord + 5], 1);
        check("b_drdata", bus.d_rdata, 32'hA5A5_0300);

        // timeout
        mem_dead = 1;
        cyc();
        bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h200;
        hi = 0; got_ack = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                got_ack = 1;
                break;
            end
            if (bus.m_req) hi++;
        end
        check("t_ack", got_ack, 1);
        check("t_mreq_cycles", hi, 8);
        check("t_err", bus.bus_err, 1);
        check("t_rdata", bus.d_rdata, 0);
        check("t_mreq_low", bus.m_req, 0);
        cyc();
        bus.d_req = 0; mem_dead = 0;
        @(negedge clk);
        check("t_err_pulse", {bus.bus_err, bus.d_ack}, 0);
        repeat (2) cyc();

        // reset during a fetch
        mem_dead = 1;
        bus.if_req = 1; bus.if_addr = 32'h40;
        cyc(); @(negedge clk);
        cyc(); @(negedge clk);
        check("r_mreq", bus.m_req, 1);
        base_if = n_if_ack;
        #2 rst_n = 1'b0;
        #1;
        check("r_mreq0", bus.m_req, 0);
        check("r_busy0", bus.busy, 0);
        check("r_maddr0", bus.m_addr, 0);
        check("r_drdata0", bus.d_rdata, 0);
        bus.if_req = 0; mem_dead = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        bus.if_req = 1; bus.if_addr = 32'h48;
        cyc(); cyc(); @(negedge clk);
        check("r_fresh_ack", bus.if_ack, 1);
        check("r_fresh_rdata", bus.if_rdata, 32'hA5A5_0048);
        cyc();
        bus.if_req = 0;
        repeat (2) cyc();
        check("r_ack_count", n_if_ack - base_if, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data/instruction memory port between the instruction-fetch requester (IF) and the load/store requester (D). The D requester is driven by the control unit's mem_rw/mem_val decode.
- Sequences each access through a request / wait / respond state machine.
- Gives D priority, bounded by a fetch anti-starvation counter.
- Aborts accesses the memory never answers, using a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DATA_BURST_MAX, 4, max consecutive D grants while if_req is pending (min 1).
- TIMEOUT_CYCLES, 255, max wait cycles for m_ready before abort (min 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  DATA_W  fetched word; valid when if_ack=1.
- d_req  in  1  data request; held with d_* stable until d_ack.
- d_we  in  1  1=store, 0=load (mem_rw encoding).
- d_size  in  2  0=byte, 1=half, 2=word (mem_val encoding); 3 reserved.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse to D.
- d_rdata  out  DATA_W  load data; valid when d_ack=1.
- m_req  out  1  memory request, held until m_ready or timeout.
- m_we  out  1  memory write enable.
- m_size  out  2  access size.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_ready  in  1  memory completion; sampled only while m_req=1.
- m_rdata  in  DATA_W  read data; valid with m_ready.
- bus_err  out  1  one-cycle pulse, coincident with the ack of an aborted access.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values, asynchronous on rst_n=0 and also applied mid-access: state=IDLE; every output 0; burst and timeout counters 0. An in-flight access is dropped without an ack.
- States and transitions:
  - IDLE -> ISSUE when any request is present.
  - ISSUE -> RESP when m_ready=1, or when the timeout counter reaches TIMEOUT_CYCLES.
  - RESP -> IDLE unconditionally.
- IDLE:
  - Grant choice: D wins if d_req=1 and the burst counter < DATA_BURST_MAX, or if if_req=0.
  - Otherwise IF wins.
  - Register owner plus the owner's addr/we/size/wdata into m_*. IF grants force m_we=0 and m_size=2.
- ISSUE:
  - m_req=1 with m_* held constant.
  - Timeout counter increments each cycle m_ready=0.
  - On m_ready=1: capture m_rdata into the owner's rdata register.
- RESP:
  - m_req=0; owner's ack=1 for exactly this cycle.
  - Requests are ignored in RESP, so a requester dropping req on ack is never double-granted.
- Latency: request seen in IDLE at cycle N -> m_req from N+1 -> m_ready at N+1+k -> ack at N+2+k. Minimum is 2 cycles (k=0, m_ready in the first ISSUE cycle).
- Burst counter:
  - +1 on a D grant while if_req=1.
  - Cleared on an IF grant, or on a D grant with if_req=0.
  - Saturates at DATA_BURST_MAX.
- Timeout: when the counter reaches TIMEOUT_CYCLES with m_ready=0:
  - m_req drops.
  - Owner's ack=1 and bus_err=1 in the RESP cycle.
  - Owner's rdata forced to 0.
  - Counter cleared on every grant.
- Store vs load: a store's rdata is undefined and its ack still pulses. Reserved d_size=3 is passed through unchanged; memory decides.
- Simultaneous requests in IDLE resolve by the priority rule in the same cycle. No idle bubble is inserted between back-to-back grants beyond RESP.
- rdata registers hold their value until the next completion for that requester.

Decomposition:
- Package riscv_mem_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - owner enum {OWN_IF, OWN_D};
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, matching the control unit's mem_val encoding.
- One sub-module, mem_arb_pick: combinational grant decision from d_req, if_req and the burst counter. The FSM, counters and registers stay in the top.

Test Plan:
- Only if_req, if_addr=0x40, memory k=0 with m_rdata=0x00500093 -> m_req in cycle 1 with m_addr=0x40, m_we=0, m_size=2; if_ack plus if_rdata=0x00500093 in cycle 2; busy low in cycle 3.
- if_req and d_req (store, d_addr=0x100, d_wdata=0xDEADBEEF, size=2) raised in the same cycle -> D granted first with m_we=1; IF granted immediately after D's RESP.
- d_req held continuously with if_req high, DATA_BURST_MAX=4 -> grant order D,D,D,D,IF,D...; if_ack occurs after exactly 4 d_acks.
- Memory never asserts m_ready, TIMEOUT_CYCLES=8, load from 0x200 -> m_req high for 8 cycles, then d_ack=1, bus_err=1, d_rdata=0 in the same cycle.
- rst_n pulsed low during ISSUE of a fetch -> all outputs 0 immediately; no if_ack; a fresh request after release completes normally.
- Requester holds req through its ack cycle, then drops it -> exactly one ack and one m_req burst; no duplicate grant.
